// File: rtl/iserdes_word_aligner.sv
// Byte aligner for the 8:1 ISERDES read path: picks one of 8 bit offsets across two
// consecutive raw words, with a training sweep that locks on a known pattern.
module iserdes_word_aligner #(
  parameter logic [7:0] PATTERN     = 8'h2D,
  parameter int         MATCH_COUNT = 4,
  parameter int         FLUSH_WORDS = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       train_start,
  input  logic       slip,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic [2:0] offset,
  output logic       busy,
  output logic       locked,
  output logic       fail
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_CHECK  = 3'd2,
    S_LOCKED = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_WORDS - 1);
  localparam logic [3:0] MATCH_LAST = 4'(MATCH_COUNT - 1);

  logic [7:0]  q_cur;
  logic [7:0]  q_prev;
  logic        valid_d;
  logic [15:0] win;

  state_t      state_reg;
  state_t      state_next;
  logic [2:0]  offset_next;
  logic [2:0]  flush_cnt_reg;
  logic [2:0]  flush_cnt_next;
  logic [3:0]  match_cnt_reg;
  logic [3:0]  match_cnt_next;
  logic        busy_next;
  logic        locked_next;
  logic        fail_next;

  assign win = {q_cur, q_prev};

  // Two-stage datapath; the offset register is used as-is at the stage-2 load.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_cur     <= '0;
      q_prev    <= '0;
      valid_d   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (in_valid) begin
        q_prev <= q_cur;
        q_cur  <= in_data;
      end
      valid_d   <= in_valid;
      out_valid <= valid_d;
      if (valid_d) begin
        out_data <= win[offset +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= S_IDLE;
      offset        <= '0;
      flush_cnt_reg <= '0;
      match_cnt_reg <= '0;
      busy          <= 1'b0;
      locked        <= 1'b0;
      fail          <= 1'b0;
    end else begin
      state_reg     <= state_next;
      offset        <= offset_next;
      flush_cnt_reg <= flush_cnt_next;
      match_cnt_reg <= match_cnt_next;
      busy          <= busy_next;
      locked        <= locked_next;
      fail          <= fail_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    offset_next    = offset;
    flush_cnt_next = flush_cnt_reg;
    match_cnt_next = match_cnt_reg;
    if (train_start) begin
      offset_next    = '0;
      flush_cnt_next = '0;
      match_cnt_next = '0;
      state_next     = S_FLUSH;
    end else begin
      case (state_reg)
        S_IDLE, S_LOCKED, S_FAIL: begin
          if (slip) begin
            offset_next = offset + 3'd1;
          end
        end
        S_FLUSH: begin
          if (out_valid) begin
            if (flush_cnt_reg == FLUSH_LAST) begin
              flush_cnt_next = '0;
              state_next     = S_CHECK;
            end else begin
              flush_cnt_next = flush_cnt_reg + 3'd1;
            end
          end
        end
        S_CHECK: begin
          // Stalled cycles hold the match count; only valid words are judged.
          if (out_valid) begin
            if (out_data == PATTERN) begin
              if (match_cnt_reg == MATCH_LAST) begin
                state_next = S_LOCKED;
              end else begin
                match_cnt_next = match_cnt_reg + 4'd1;
              end
            end else if (offset == 3'd7) begin
              state_next = S_FAIL;
            end else begin
              offset_next    = offset + 3'd1;
              match_cnt_next = '0;
              flush_cnt_next = '0;
              state_next     = S_FLUSH;
            end
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Flags decode the upcoming state so they change on the same edge as the state.
  always_comb begin
    busy_next   = (state_next == S_FLUSH) || (state_next == S_CHECK);
    locked_next = (state_next == S_LOCKED);
    fail_next   = (state_next == S_FAIL);
  end

endmodule
